captura_lectura_rtc: RTL and testbench

Read-back sequencer for the RTC controller: on a start pulse it walks the nine time, date and timer fields, requests each byte from the RTC bus interface, and captures the returned BCD byte into a per-field holding register. It is the read-side counterpart of the load-select path that feeds BCD values toward the RTC. Its outputs drive the display formatter and the counter preload logic.

---
 rtl/captura_lectura_rtc.sv | 147 ++++++++++++++
 tb/tb_captura_lectura_rtc.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/captura_lectura_rtc.sv
// Read-back sequencer: sweeps the nine RTC fields, capturing each returned BCD byte.
// Optional CAPTURA_BCD_CHECK_EN rejects non-BCD bytes and adds the sticky bcd_err output.
module captura_lectura_rtc #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] rd_data,
  input  logic       rd_valid,
  output logic       rd_req,
  output logic [3:0] sel_rd,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] day,
  output logic [7:0] month,
  output logic [7:0] year,
  output logic [7:0] seg_t,
  output logic [7:0] min_t,
  output logic [7:0] hora_t
`ifdef CAPTURA_BCD_CHECK_EN
  ,
  output logic       bcd_err
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  localparam logic [7:0] CntLimit = 8'(TIMEOUT - 1);
  localparam logic [3:0] LastSel  = 4'd8;

  state_e     state_q, state_d;
  logic       start_q, start_d;
  logic [3:0] sel_q, sel_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
  logic [7:0] field_q [9];
  logic [7:0] field_d [9];
  logic [7:0] cap_byte;
  logic       cap_ok;
  logic       bcd_err_q, bcd_err_d;

  // Hour fields drop the RTC 12/24 mode bit before any check or store.
  always_comb begin
    cap_byte = rd_data;
    if (sel_q == 4'd2 || sel_q == 4'd8) begin
      cap_byte = {1'b0, rd_data[6:0]};
    end
`ifdef CAPTURA_BCD_CHECK_EN
    cap_ok = (cap_byte[7:4] <= 4'd9) && (cap_byte[3:0] <= 4'd9);
`else
    cap_ok = 1'b1;
`endif
  end

  always_comb begin
    state_d   = state_q;
    start_d   = start & (state_q == StIdle);
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    bcd_err_d = bcd_err_q;
    field_d   = field_q;
    unique case (state_q)
      StIdle: begin
        if (start_q) begin
          state_d   = StReq;
          sel_d     = 4'd0;
          timeout_d = 1'b0;
          bcd_err_d = 1'b0;
        end
      end
      StReq: begin
        state_d = StWait;
        cnt_d   = 8'd0;
      end
      StWait: begin
        // rd_valid takes priority over the timeout limit in the same cycle.
        if (rd_valid) begin
          if (cap_ok) begin
            for (int i = 0; i < 9; i++) begin
              if (sel_q == 4'(i)) field_d[i] = cap_byte;
            end
          end else begin
            bcd_err_d = 1'b1;
          end
          if (sel_q == LastSel) begin
            state_d = StDone;
          end else begin
            sel_d   = sel_q + 4'd1;
            state_d = StReq;
          end
        end else if (cnt_q == CntLimit) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      sel_q     <= 4'd0;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
      bcd_err_q <= 1'b0;
      field_q   <= '{default: 8'h00};
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      bcd_err_q <= bcd_err_d;
      field_q   <= field_d;
    end
  end

  assign rd_req  = (state_q == StReq);
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign sel_rd  = sel_q;
  assign timeout = timeout_q;
  assign seg     = field_q[0];
  assign min     = field_q[1];
  assign hora    = field_q[2];
  assign day     = field_q[3];
  assign month   = field_q[4];
  assign year    = field_q[5];
  assign seg_t   = field_q[6];
  assign min_t   = field_q[7];
  assign hora_t  = field_q[8];
`ifdef CAPTURA_BCD_CHECK_EN
  assign bcd_err = bcd_err_q;
`endif

endmodule

// File: tb/tb_captura_lectura_rtc.sv
// Directed bench for captura_lectura_rtc with a responder and an expected-capture queue.
module tb_captura_lectura_rtc;

  localparam int unsigned TO = 10;

  logic       clk = 1'b0;
  logic       reset, start, rd_valid;
  logic [7:0] rd_data;
  logic       rd_req, busy, done, timeout;
  logic [3:0] sel_rd;
  logic [7:0] seg, min, hora, day, month, year, seg_t, min_t, hora_t;
`ifdef CAPTURA_BCD_CHECK_EN
  logic       bcd_err;
`endif

  always #5 clk = ~clk;

  captura_lectura_rtc #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_req   (rd_req),
    .sel_rd   (sel_rd),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .seg      (seg),
    .min      (min),
    .hora     (hora),
    .day      (day),
    .month    (month),
    .year     (year),
    .seg_t    (seg_t),
    .min_t    (min_t),
    .hora_t   (hora_t)
`ifdef CAPTURA_BCD_CHECK_EN
    ,
    .bcd_err  (bcd_err)
`endif
  );

  typedef struct {
    int         f;
    logic [7:0] v;
  } exp_t;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] model [9];
  exp_t       sb [$];
  logic       exp_bcd_err;

  function automatic logic [7:0] field_out(int f);
    case (f)
      0: return seg;
      1: return min;
      2: return hora;
      3: return day;
      4: return month;
      5: return year;
      6: return seg_t;
      7: return min_t;
      8: return hora_t;
      default: return 8'hxx;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fields(input string tag);
    for (int i = 0; i < 9; i++) chk($sformatf("%s_f%0d", tag, i), field_out(i), model[i]);
  endtask

  // Model of one capture: hour bit 7 masked, optional BCD rejection.
  task automatic push_exp(input int f, input logic [7:0] d);
    logic [7:0] m;
    m = (f == 2 || f == 8) ? {1'b0, d[6:0]} : d;
`ifdef CAPTURA_BCD_CHECK_EN
    if (m[7:4] > 4'd9 || m[3:0] > 4'd9) begin
      m = model[f];
      exp_bcd_err = 1'b1;
    end
`endif
    model[f] = m;
    sb.push_back('{f: f, v: m});
  endtask

  task automatic sweep(input string tag, input logic [7:0] data [9], input int lat,
                       input int silent, input int restart_at, input int exp_done,
                       input int exp_reqs, input logic exp_to);
    int   reqs;
    int   drive_at;
    int   drive_f;
    int   done_at;
    logic pending;
    exp_t e;
    reqs = 0; drive_at = -1; drive_f = 0; done_at = -1; pending = 1'b0;
    exp_bcd_err = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 150; c++) begin
      tick();
      if (pending) begin
        rd_valid = 1'b0;
        e = sb.pop_front();
        chk($sformatf("%s_cap_f%0d", tag, e.f), field_out(e.f), e.v);
        pending = 1'b0;
      end
      if (c == 1) begin
        chk({tag, "_busy_rise"}, busy, 1);
        chk({tag, "_req_first"}, rd_req, 1);
      end
      start = (c == restart_at);
      if (done) begin
        done_at = c;
        break;
      end
      if (rd_req) begin
        chk($sformatf("%s_sel_%0d", tag, reqs), sel_rd, reqs);
        reqs++;
        if (int'(sel_rd) != silent) begin
          drive_at = c + 1 + lat;
          drive_f  = int'(sel_rd);
        end
      end
      if (c == drive_at) begin
        rd_valid = 1'b1;
        rd_data  = data[drive_f];
        push_exp(drive_f, data[drive_f]);
        pending = 1'b1;
      end
    end
    start    = 1'b0;
    rd_valid = 1'b0;
    chk({tag, "_done_cycle"}, done_at, exp_done);
    chk({tag, "_req_count"}, reqs, exp_reqs);
    chk({tag, "_timeout"}, timeout, exp_to);
`ifdef CAPTURA_BCD_CHECK_EN
    chk({tag, "_bcd_err"}, bcd_err, exp_bcd_err);
`endif
    tick();
    chk({tag, "_busy_fall"}, busy, 0);
    chk({tag, "_done_pulse"}, done, 0);
    check_fields(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_req"}, rd_req, 0);
    chk({tag, "_sel"}, sel_rd, 0);
    chk({tag, "_timeout"}, timeout, 0);
`ifdef CAPTURA_BCD_CHECK_EN
    chk({tag, "_bcd_err"}, bcd_err, 0);
`endif
    check_fields(tag);
  endtask

  logic [7:0] da [9] = '{8'h45, 8'h30, 8'h92, 8'h15, 8'h07, 8'h16, 8'h10, 8'h05, 8'h81};
  logic [7:0] db [9] = '{8'h12, 8'h34, 8'h21, 8'h28, 8'h11, 8'h24, 8'h55, 8'h44, 8'h09};
  logic [7:0] dc [9] = '{8'h01, 8'h02, 8'h83, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
  logic [7:0] dd [9] = '{8'h59, 8'h58, 8'hA3, 8'h3A, 8'h12, 8'h99, 8'h00, 8'h01, 8'h19};

  initial begin
    logic found;
    logic resp;
    reset = 1'b1; start = 1'b0; rd_valid = 1'b0; rd_data = 8'h00;
    for (int i = 0; i < 9; i++) model[i] = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_reset_outputs("rst");

    // rd_valid while idle must not touch the fields.
    rd_valid = 1'b1; rd_data = 8'h55;
    tick(); tick();
    rd_valid = 1'b0;
    tick();
    check_fields("idle_valid");
    chk("idle_busy", busy, 0);

    sweep("zw",  da, 0, -1, -1, 19, 9, 1'b0);
    sweep("lat", db, 3, -1,  7, 46, 9, 1'b0);
    sweep("to",  dc, 0,  4, -1, 20, 5, 1'b1);
    sweep("bcd", dd, 1, -1, -1, 28, 9, 1'b0);

    // Reset during the field-5 wait with rd_valid pending.
    found = 1'b0; resp = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 60; c++) begin
      tick();
      rd_valid = 1'b0;
      if (resp) begin
        rd_valid = 1'b1;
        rd_data  = 8'h11;
        resp     = 1'b0;
      end
      if (rd_req) begin
        if (sel_rd == 4'd5) begin
          found = 1'b1;
          break;
        end
        resp = 1'b1;
      end
    end
    chk("mid_found_sel5", found, 1);
    rd_valid = 1'b0;
    tick();
    chk("mid_wait_sel", sel_rd, 5);
    reset = 1'b1; rd_valid = 1'b1; rd_data = 8'h22;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 9; i++) model[i] = 8'h00;
    check_reset_outputs("mid_rst");
    tick();
    rd_valid = 1'b0;
    check_fields("late_valid");
    chk("late_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
